// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared fixed-point constants, layer encodings, descriptor and stream FSM types
package nn_pkg;

    localparam int PARSIZE    = 16;
    localparam int DATSIZE    = 16;
    localparam int FPSHIFT    = 8;
    localparam int DESC_WADDR = 16;
    localparam int DESC_BADDR = 8;
    localparam int DESC_CNTW  = 8;

    typedef enum logic [2:0] {
        CONV1,
        CONV2,
        CONV3,
        DENSE1
    } layer_t;

    typedef struct packed {
        logic [DESC_WADDR-1:0] base_w;
        logic [DESC_BADDR-1:0] base_b;
        logic [DESC_CNTW-1:0]  n_out;
        logic [DESC_CNTW-1:0]  n_in;
    } layer_desc_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_FIN
    } stream_state_t;

endpackage

// File: rtl/param_fifo.sv
// rtl/param_fifo.sv - synchronous FIFO with count/full/empty, head presented combinationally
module param_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign count   = count_q;
    assign dout    = mem[rd_ptr_q];
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/param_stream.sv
// rtl/param_stream.sv - walks the weight ROM for one layer and streams weight/bias beats
module param_stream #(
    parameter int PARSIZE    = 16,
    parameter int WORDS      = 9,
    parameter int WADDR      = 16,
    parameter int BADDR      = 8,
    parameter int CNTW       = 8,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [WADDR-1:0]         base_w,
    input  logic [BADDR-1:0]         base_b,
    input  logic [CNTW-1:0]          n_out,
    input  logic [CNTW-1:0]          n_in,
    output logic                     busy,
    output logic                     done,
    output logic                     w_en,
    output logic [WADDR-1:0]         w_addr,
    input  logic [WORDS*PARSIZE-1:0] w_data,
    output logic [BADDR-1:0]         b_addr,
    input  logic [PARSIZE-1:0]       b_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WORDS*PARSIZE-1:0] out_weights,
    output logic [PARSIZE-1:0]       out_bias,
    output logic                     out_first,
    output logic                     out_last_in,
    output logic                     out_last
);

    import nn_pkg::*;

    localparam int TAGW  = PARSIZE + 3;
    localparam int WW    = WORDS * PARSIZE;
    localparam int WIDTH = WW + TAGW;
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int SUMW  = CW + 1;

    stream_state_t    state_q;
    stream_state_t    state_d;

    logic [WADDR-1:0] addr_q;
    logic [BADDR-1:0] bias_addr_q;
    logic [CNTW-1:0]  n_out_q;
    logic [CNTW-1:0]  n_in_q;
    logic [CNTW-1:0]  o_q;
    logic [CNTW-1:0]  i_q;
    logic [CW-1:0]    inflight_q;

    logic [RD_LAT-1:0] pipe_vld_q;
    logic [TAGW-1:0]   pipe_tag_q [RD_LAT];

    logic [CW-1:0]    fifo_count;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_din;
    logic [WIDTH-1:0] fifo_dout;

    logic credit;
    logic issue;
    logic push;
    logic pop;
    logic first_w;
    logic last_in;
    logic last_out;
    logic last_issue;
    logic drain_done;

    // Outstanding beats are those already in the FIFO plus reads still in the ROM pipeline.
    assign credit     = !fifo_full &&
                        (({1'b0, fifo_count} + {1'b0, inflight_q}) < SUMW'(FIFO_DEPTH));
    assign issue      = (state_q == ST_ISSUE) && credit;
    assign first_w    = (i_q == '0);
    assign last_in    = (i_q == n_in_q - CNTW'(1));
    assign last_out   = (o_q == n_out_q - CNTW'(1));
    assign last_issue = last_in && last_out;

    assign push       = pipe_vld_q[RD_LAT-1];
    assign fifo_din   = {w_data, pipe_tag_q[RD_LAT-1]};
    assign pop        = out_valid && out_ready;
    assign drain_done = (inflight_q == '0) &&
                        (fifo_empty || (pop && fifo_count == CW'(1)));

    assign busy   = (state_q != ST_IDLE);
    assign done   = (state_q == ST_FIN);
    assign w_en   = issue;
    assign w_addr = addr_q;
    assign b_addr = bias_addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ((n_out == '0) || (n_in == '0)) ? ST_FIN : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (issue && last_issue) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_done) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output-major walk is contiguous, so the weight address is a plain running increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            bias_addr_q <= '0;
            n_out_q     <= '0;
            n_in_q      <= '0;
            o_q         <= '0;
            i_q         <= '0;
        end else if ((state_q == ST_IDLE) && start) begin
            addr_q      <= base_w;
            bias_addr_q <= base_b;
            n_out_q     <= n_out;
            n_in_q      <= n_in;
            o_q         <= '0;
            i_q         <= '0;
        end else if (issue) begin
            addr_q <= addr_q + WADDR'(1);
            if (last_in) begin
                i_q         <= '0;
                o_q         <= o_q + CNTW'(1);
                bias_addr_q <= bias_addr_q + BADDR'(1);
            end else begin
                i_q <= i_q + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= '0;
        end else begin
            case ({issue, push})
                2'b10:   inflight_q <= inflight_q + CW'(1);
                2'b01:   inflight_q <= inflight_q - CW'(1);
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    // Tag travels beside the read so bias and flags meet their weight word at the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_q <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                pipe_tag_q[k] <= '0;
            end
        end else begin
            pipe_vld_q[0] <= issue;
            pipe_tag_q[0] <= {b_data, first_w, last_in, last_issue};
            for (int k = 1; k < RD_LAT; k++) begin
                pipe_vld_q[k] <= pipe_vld_q[k-1];
                pipe_tag_q[k] <= pipe_tag_q[k-1];
            end
        end
    end

    param_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (fifo_din),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        out_valid   = !fifo_empty;
        out_weights = '0;
        out_bias    = '0;
        out_first   = 1'b0;
        out_last_in = 1'b0;
        out_last    = 1'b0;
        if (!fifo_empty) begin
            out_weights = fifo_dout[WIDTH-1 -: WW];
            out_bias    = fifo_dout[TAGW-1 -: PARSIZE];
            out_first   = fifo_dout[2];
            out_last_in = fifo_dout[1];
            out_last    = fifo_dout[0];
        end
    end

endmodule

// File: tb/tb_param_stream.sv
// tb/tb_param_stream.sv - directed self-checking bench for param_stream
module tb_param_stream;

    typedef struct packed {
        logic [143:0] w;
        logic [15:0]  b;
        logic [2:0]   fl;
        logic [31:0]  cyc;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [15:0] base_w;
    logic [7:0]  base_b, n_out, n_in;

    logic         start1, busy1, done1, w_en1, out_valid1, out_ready1;
    logic         out_first1, out_last_in1, out_last1;
    logic [15:0]  w_addr1, b_data1, out_bias1;
    logic [7:0]   b_addr1;
    logic [143:0] w_data1, out_weights1;

    logic         start3, busy3, done3, w_en3, out_valid3, out_ready3;
    logic         out_first3, out_last_in3, out_last3;
    logic [15:0]  w_addr3, b_data3, out_bias3;
    logic [7:0]   b_addr3;
    logic [143:0] w_data3, out_weights3, d3_a, d3_b;

    param_stream #(.RD_LAT(1), .FIFO_DEPTH(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .base_w(base_w), .base_b(base_b),
        .n_out(n_out), .n_in(n_in), .busy(busy1), .done(done1), .w_en(w_en1),
        .w_addr(w_addr1), .w_data(w_data1), .b_addr(b_addr1), .b_data(b_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_weights(out_weights1),
        .out_bias(out_bias1), .out_first(out_first1), .out_last_in(out_last_in1),
        .out_last(out_last1)
    );

    param_stream #(.RD_LAT(3), .FIFO_DEPTH(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .base_w(base_w), .base_b(base_b),
        .n_out(n_out), .n_in(n_in), .busy(busy3), .done(done3), .w_en(w_en3),
        .w_addr(w_addr3), .w_data(w_data3), .b_addr(b_addr3), .b_data(b_data3),
        .out_valid(out_valid3), .out_ready(out_ready3), .out_weights(out_weights3),
        .out_bias(out_bias3), .out_first(out_first3), .out_last_in(out_last_in3),
        .out_last(out_last3)
    );

    // ROM models: weight word = address replicated, bias = 0xB0 : address; all-ones when not read
    assign b_data1 = {8'hB0, b_addr1};
    assign b_data3 = {8'hB0, b_addr3};
    always @(posedge clk) w_data1 <= w_en1 ? {9{w_addr1}} : '1;
    always @(posedge clk) begin
        d3_a    <= w_en3 ? {9{w_addr3}} : '1;
        d3_b    <= d3_a;
        w_data3 <= d3_b;
    end

    int    cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    beat_t        bq[$];
    logic [23:0]  wq[$];
    beat_t        cur_beat;
    logic [163:0] cur_head, hold_head;
    logic         held = 1'b0;
    int issued = 0, popped = 0, credit_viol = 0, max_out = 0, unstable = 0;
    int done_cnt = 0, done_cyc = 0, busy_cnt = 0, start_cyc = 0;

    assign cur_beat = {out_weights1, out_bias1, out_first1, out_last_in1, out_last1, 32'(cyc)};
    assign cur_head = {out_valid1, out_weights1, out_bias1, out_first1, out_last_in1, out_last1};

    always @(negedge clk) begin
        if (!rst_n) begin
            issued <= 0;
            popped <= 0;
            held   <= 1'b0;
        end else begin
            if (start1 && !busy1) start_cyc <= cyc;
            if (w_en1) begin
                wq.push_back({b_addr1, w_addr1});
                issued <= issued + 1;
                if (issued - popped >= 4) credit_viol <= credit_viol + 1;
                if (issued - popped + 1 > max_out) max_out <= issued - popped + 1;
            end
            if (out_valid1 && out_ready1) begin
                bq.push_back(cur_beat);
                popped <= popped + 1;
            end
            if (held && cur_head != hold_head) unstable <= unstable + 1;
            held      <= out_valid1 && !out_ready1;
            hold_head <= cur_head;
            if (done1) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (busy1) busy_cnt <= busy_cnt + 1;
        end
    end

    int checks = 0;
    int errors = 0;
    logic bp = 1'b0;
    int step_k = 0;

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        step_k++;
        out_ready1 = bp ? ((step_k % 4 == 0) || (step_k % 4 == 3)) : 1'b1;
    endtask

    task automatic start_layer1(input logic [15:0] bw, input logic [7:0] bb,
                                input logic [7:0] no, input logic [7:0] ni);
        base_w = bw; base_b = bb; n_out = no; n_in = ni;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
    endtask

    task automatic wait_done1(input int max_cyc);
        int base;
        base = done_cnt;
        for (int k = 0; k < max_cyc && done_cnt == base; k++) step();
        check("wait_done", 160'(done_cnt != base), 160'(1));
    endtask

    // 2x3 layer at base_w=100, base_b=16
    task automatic check_walk(input string tag, input int bi, input int wi);
        logic [15:0] ea;
        check({tag, "_nbeats"}, 160'(bq.size() - bi), 160'(6));
        check({tag, "_nreads"}, 160'(wq.size() - wi), 160'(6));
        for (int k = 0; k < 6; k++) begin
            ea = 16'(100 + k);
            check({tag, "_raddr"}, 160'(wq[wi+k]), 160'({8'(16 + k / 3), ea}));
            check({tag, "_w"}, 160'(bq[bi+k].w), 160'({9{ea}}));
            check({tag, "_b"}, 160'(bq[bi+k].b), 160'({8'hB0, 8'(16 + k / 3)}));
            check({tag, "_flags"}, 160'(bq[bi+k].fl),
                  160'({k % 3 == 0, k % 3 == 2, k == 5}));
        end
        check({tag, "_done_after_last"}, 160'(done_cyc - int'(bq[bi+5].cyc)), 160'(1));
    endtask

    int bi, wi, d0, bz;
    logic [15:0] exp3 [4];

    initial begin
        rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; out_ready1 = 1'b1; out_ready3 = 1'b1;
        base_w = '0; base_b = '0; n_out = '0; n_in = '0;
        exp3[0] = 16'hFFFE; exp3[1] = 16'hFFFF; exp3[2] = 16'h0000; exp3[3] = 16'h0001;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy_done_wen", 160'({busy1, done1, w_en1, out_valid1}), 160'(0));
        check("rst_addrs", 160'({w_addr1, b_addr1}), 160'(0));
        check("rst_out_data", 160'({out_weights1, out_bias1, out_first1, out_last_in1, out_last1}), 160'(0));
        rst_n = 1'b1;
        step();

        // basic walk
        bi = bq.size(); wi = wq.size(); d0 = done_cnt; bz = busy_cnt;
        start_layer1(16'd100, 8'd16, 8'd2, 8'd3);
        wait_done1(40);
        repeat (2) step();
        check_walk("basic", bi, wi);
        check("basic_latency", 160'(int'(bq[bi].cyc) - start_cyc), 160'(3));
        check("basic_done_cnt", 160'(done_cnt - d0), 160'(1));
        check("basic_busy_cycles", 160'(busy_cnt - bz), 160'(9));

        // backpressure with out_ready 1,0,0,1,...
        bp = 1'b1; step_k = 3;
        bi = bq.size(); wi = wq.size(); d0 = done_cnt;
        start_layer1(16'd100, 8'd16, 8'd2, 8'd3);
        wait_done1(80);
        bp = 1'b0;
        repeat (2) step();
        check_walk("bp", bi, wi);
        check("bp_credit_violations", 160'(credit_viol), 160'(0));
        check("bp_max_outstanding", 160'(max_out), 160'(4));
        check("bp_hold_unstable", 160'(unstable), 160'(0));
        check("bp_done_cnt", 160'(done_cnt - d0), 160'(1));

        // degenerate layers: n_out=0, then n_in=0
        for (int r = 0; r < 2; r++) begin
            bi = bq.size(); wi = wq.size(); d0 = done_cnt; bz = busy_cnt;
            start_layer1(16'd300, 8'd5, (r == 0) ? 8'd0 : 8'd2, (r == 0) ? 8'd3 : 8'd0);
            repeat (3) step();
            check("degen_reads", 160'(wq.size() - wi), 160'(0));
            check("degen_beats", 160'(bq.size() - bi), 160'(0));
            check("degen_done_cnt", 160'(done_cnt - d0), 160'(1));
            check("degen_done_cyc", 160'(done_cyc - start_cyc), 160'(1));
            check("degen_busy_cycles", 160'(busy_cnt - bz), 160'(1));
        end

        // RD_LAT=3 instance, address wrap
        base_w = 16'hFFFE; base_b = 8'd3; n_out = 8'd1; n_in = 8'd4;
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("lat3_wen", 160'({w_en3, busy3}), 160'(2'b11));
            check("lat3_waddr", 160'(w_addr3), 160'(exp3[k]));
            check("lat3_not_valid_yet", 160'(out_valid3), 160'(0));
            @(posedge clk); #1;
        end
        for (int k = 0; k < 4; k++) begin
            check("lat3_valid", 160'({out_valid3, w_en3}), 160'(2'b10));
            check("lat3_w", 160'(out_weights3), 160'({9{exp3[k]}}));
            check("lat3_b_flags", 160'({out_bias3, out_first3, out_last_in3, out_last3}),
                  160'({16'hB003, k == 0, k == 3, k == 3}));
            @(posedge clk); #1;
        end
        check("lat3_done", 160'({done3, busy3, out_valid3}), 160'(3'b110));
        @(posedge clk); #1;
        check("lat3_idle", 160'({done3, busy3}), 160'(0));

        // reset abort mid-issue of a 4x8 layer
        start_layer1(16'd500, 8'd60, 8'd4, 8'd8);
        repeat (5) step();
        #2 rst_n = 1'b0;
        #1;
        check("abort_ctrl", 160'({busy1, done1, w_en1, out_valid1}), 160'(0));
        check("abort_addrs", 160'({w_addr1, b_addr1}), 160'(0));
        check("abort_out_data", 160'({out_weights1, out_bias1, out_first1, out_last_in1, out_last1}), 160'(0));
        d0 = done_cnt;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) step();
        check("abort_no_done", 160'(done_cnt - d0), 160'(0));
        bi = bq.size(); wi = wq.size();
        start_layer1(16'd200, 8'd40, 8'd1, 8'd2);
        wait_done1(30);
        repeat (2) step();
        check("post_abort_nbeats", 160'(bq.size() - bi), 160'(2));
        check("post_abort_raddr0", 160'(wq[wi]), 160'({8'd40, 16'd200}));
        check("post_abort_raddr1", 160'(wq[wi+1]), 160'({8'd40, 16'd201}));
        check("post_abort_beat0", 160'({bq[bi].w, bq[bi].b, bq[bi].fl}),
              160'({{9{16'd200}}, 16'hB028, 3'b100}));
        check("post_abort_beat1", 160'({bq[bi+1].w, bq[bi+1].b, bq[bi+1].fl}),
              160'({{9{16'd201}}, 16'hB028, 3'b011}));

        // start pulse with another descriptor during DRAIN is ignored
        bi = bq.size(); wi = wq.size(); d0 = done_cnt; bz = busy_cnt;
        start_layer1(16'd100, 8'd16, 8'd2, 8'd3);
        repeat (6) step();
        base_w = 16'd900; base_b = 8'd99; n_out = 8'd5; n_in = 8'd5;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        wait_done1(40);
        repeat (4) step();
        check_walk("busy_start", bi, wi);
        check("busy_start_done_cnt", 160'(done_cnt - d0), 160'(1));
        check("busy_start_done_cyc", 160'(done_cyc - start_cyc), 160'(9));
        check("busy_start_busy_cycles", 160'(busy_cnt - bz), 160'(9));
        check("busy_start_idle", 160'({busy1, w_en1, out_valid1}), 160'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
